// File: rtl/itch_pkg.sv
// Shared ITCH 5.0 constants, framer state encoding and the per-type length lookup.
package itch_pkg;

  localparam logic [7:0] TYPE_ADD      = 8'h41;  // 'A'
  localparam logic [7:0] TYPE_ADD_MPID = 8'h46;  // 'F'
  localparam logic [7:0] TYPE_EXEC     = 8'h45;  // 'E'
  localparam logic [7:0] TYPE_CANCEL   = 8'h58;  // 'X'
  localparam logic [7:0] TYPE_DELETE   = 8'h44;  // 'D'
  localparam logic [7:0] TYPE_REPLACE  = 8'h55;  // 'U'

  localparam logic [15:0] LEN_ADD      = 16'd36;
  localparam logic [15:0] LEN_ADD_MPID = 16'd40;
  localparam logic [15:0] LEN_EXEC     = 16'd31;
  localparam logic [15:0] LEN_CANCEL   = 16'd23;
  localparam logic [15:0] LEN_DELETE   = 16'd19;
  localparam logic [15:0] LEN_REPLACE  = 16'd35;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    BODY,
    SKIP,
    PLAY
  } state_t;

  // Zero means the type is not one we police.
  function automatic logic [15:0] expected_len(input logic [7:0] msg_type);
    case (msg_type)
      TYPE_ADD:      expected_len = LEN_ADD;
      TYPE_ADD_MPID: expected_len = LEN_ADD_MPID;
      TYPE_EXEC:     expected_len = LEN_EXEC;
      TYPE_CANCEL:   expected_len = LEN_CANCEL;
      TYPE_DELETE:   expected_len = LEN_DELETE;
      TYPE_REPLACE:  expected_len = LEN_REPLACE;
      default:       expected_len = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_msg_buf.sv
// Message body buffer: one write port, one registered read port. A read of the
// address being written returns the new byte so a 1-byte message replays on time.
module itch_msg_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/itch_framer.sv
// itch_framer: buffers 2-byte length-prefixed ITCH messages and replays each as a gap-free burst.
// Optional FRAMER_TYPE_CHECK_EN: known types whose length disagrees are replayed with valid=0.
module itch_framer
  import itch_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       message,
  output logic             valid,
  output logic             start_msg,
  output logic             end_msg,
  output logic             err_trunc,
  output logic             err_oversize,
  output logic [CNT_W-1:0] err_count
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  state_t state_reg, state_next;
  logic [15:0] len_reg, len_next;
  // Write index in BODY, consumed count in SKIP, next read address in PLAY.
  logic [15:0] idx_reg, idx_next;
  logic in_ready_reg, in_ready_next;
  logic act_reg, act_next;
  logic start_reg, start_next;
  logic end_reg, end_next;
  logic valid_reg, valid_next;
  logic trunc_reg, trunc_next;
  logic over_reg, over_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic accept, last_byte, wr_en, type_bad, type_err, err_event;
  logic [15:0] len_full;
  logic [AW-1:0] rd_addr;
  logic [7:0] rd_data;

`ifdef FRAMER_TYPE_CHECK_EN
  logic [7:0] type_reg, type_next, msg_type;
  logic [15:0] type_len;

  assign msg_type  = (idx_reg == 16'd0) ? in_data : type_reg;
  assign type_len  = expected_len(msg_type);
  assign type_bad  = (type_len != 16'd0) && (type_len != len_reg);
  assign type_next = (state_reg == BODY && accept && idx_reg == 16'd0) ? in_data : type_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      type_reg <= 8'h00;
    end else begin
      type_reg <= type_next;
    end
  end
`else
  assign type_bad = 1'b0;
`endif

  assign accept    = in_valid && in_ready_reg;
  assign len_full  = {len_reg[15:8], in_data};
  assign last_byte = (idx_reg == len_reg - 16'd1);
  assign rd_addr   = (state_reg == PLAY) ? idx_reg[AW-1:0] : '0;

  itch_msg_buf #(
    .DEPTH(MAX_LEN),
    .AW   (AW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(idx_reg[AW-1:0]),
    .wr_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    act_next   = 1'b0;
    start_next = 1'b0;
    end_next   = 1'b0;
    valid_next = 1'b0;
    trunc_next = 1'b0;
    over_next  = 1'b0;
    type_err   = 1'b0;
    wr_en      = 1'b0;

    case (state_reg)
      LEN_HI: begin
        if (accept) begin
          len_next = {in_data, 8'h00};
          if (in_last) begin
            trunc_next = 1'b1;
          end else begin
            state_next = LEN_LO;
          end
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_next = len_full;
          idx_next = 16'd0;
          if (len_full == 16'd0) begin
            state_next = LEN_HI;
          end else if (len_full > MAX_LEN_W) begin
            over_next  = 1'b1;
            state_next = in_last ? LEN_HI : SKIP;
          end else if (in_last) begin
            trunc_next = 1'b1;
            state_next = LEN_HI;
          end else begin
            state_next = BODY;
          end
        end
      end
      BODY: begin
        if (accept) begin
          wr_en = 1'b1;
          if (last_byte) begin
            // Read of byte 0 is issued this cycle so the burst starts next cycle.
            state_next = PLAY;
            idx_next   = 16'd1;
            act_next   = 1'b1;
            start_next = 1'b1;
            end_next   = (len_reg == 16'd1);
            valid_next = ~type_bad;
            type_err   = type_bad;
          end else if (in_last) begin
            trunc_next = 1'b1;
            state_next = LEN_HI;
          end else begin
            idx_next = idx_reg + 16'd1;
          end
        end
      end
      SKIP: begin
        if (accept) begin
          if (last_byte || in_last) begin
            state_next = LEN_HI;
          end else begin
            idx_next = idx_reg + 16'd1;
          end
        end
      end
      PLAY: begin
        if (idx_reg == len_reg) begin
          state_next = LEN_HI;
        end else begin
          act_next   = 1'b1;
          valid_next = valid_reg;
          end_next   = (idx_reg == len_reg - 16'd1);
          idx_next   = idx_reg + 16'd1;
        end
      end
      default: state_next = LEN_HI;
    endcase

    in_ready_next = (state_next != PLAY);
    err_event     = trunc_next | over_next | type_err;
    cnt_next      = (err_event && (cnt_reg != '1)) ? cnt_reg + CNT_W'(1) : cnt_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= LEN_HI;
      len_reg      <= 16'd0;
      idx_reg      <= 16'd0;
      in_ready_reg <= 1'b0;
      act_reg      <= 1'b0;
      start_reg    <= 1'b0;
      end_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      trunc_reg    <= 1'b0;
      over_reg     <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      idx_reg      <= idx_next;
      in_ready_reg <= in_ready_next;
      act_reg      <= act_next;
      start_reg    <= start_next;
      end_reg      <= end_next;
      valid_reg    <= valid_next;
      trunc_reg    <= trunc_next;
      over_reg     <= over_next;
      cnt_reg      <= cnt_next;
    end
  end

  assign in_ready     = in_ready_reg;
  assign message      = act_reg ? rd_data : 8'h00;
  assign valid        = valid_reg;
  assign start_msg    = start_reg;
  assign end_msg      = end_reg;
  assign err_trunc    = trunc_reg;
  assign err_oversize = over_reg;
  assign err_count    = cnt_reg;

endmodule

// File: tb/tb_itch_framer.sv
// Bench for itch_framer: table rows, hand-written corner sequences and random payloads
// checked against a payload-level reference model.
`timescale 1ns/1ps
module tb_itch_framer;

  localparam int MAX_LEN = 64;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef logic [7:0] u8;

  typedef struct {
    logic [15:0] len;
    int          nbody;
    u8           typ;
    int          exp_msgs;
    int          exp_tr;
    int          exp_ov;
    bit          tmis;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready, valid, start_msg, end_msg, err_trunc, err_oversize;
  logic [7:0] message;
  logic [CW-1:0] err_count;

  itch_framer #(.MAX_LEN(MAX_LEN), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .message     (message),
    .valid       (valid),
    .start_msg   (start_msg),
    .end_msg     (end_msg),
    .err_trunc   (err_trunc),
    .err_oversize(err_oversize),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  int cyc = 0;
  bit in_burst = 0;
  u8 cur[$];
  bit cur_all_v, cur_any_v;
  u8 got_bytes[$];
  int got_lens[$];
  bit got_valid[$];
  int mixed_valid = 0, ready_viol = 0, idle_viol = 0, runaway = 0;
  int trunc_seen = 0, over_seen = 0;
  int last_start_cyc = 0, last_acc_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_burst = 0;
      cur.delete();
    end else begin
      if (err_trunc) trunc_seen++;
      if (err_oversize) over_seen++;
      if (start_msg) begin
        in_burst = 1;
        cur.delete();
        cur_all_v = 1;
        cur_any_v = 0;
        last_start_cyc = cyc;
      end
      if (in_burst) begin
        cur.push_back(message);
        cur_all_v &= valid;
        cur_any_v |= valid;
        if (in_ready) ready_viol++;
        if (end_msg) begin
          foreach (cur[i]) got_bytes.push_back(cur[i]);
          got_lens.push_back(cur.size());
          got_valid.push_back(cur_all_v);
          if (cur_all_v != cur_any_v) mixed_valid++;
          in_burst = 0;
        end else if (cur.size() > MAX_LEN + 2) begin
          runaway++;
          in_burst = 0;
        end
      end else if (valid || end_msg || (message != 8'h00)) begin
        idle_viol++;
      end
    end
  end

  // ---------------- reference model ----------------
  u8 exp_bytes[$];
  int exp_lens[$];
  bit exp_valid[$];
  int exp_err = 0, exp_trunc = 0, exp_over = 0;
  u8 types[6] = '{8'h41, 8'h46, 8'h45, 8'h58, 8'h44, 8'h55};

  function automatic int itch_len(input u8 t);
    case (t)
      8'h41: return 36;
      8'h46: return 40;
      8'h45: return 31;
      8'h58: return 23;
      8'h44: return 19;
      8'h55: return 35;
      default: return 0;
    endcase
  endfunction

  // Walks one UDP payload: each record is a 2-byte length then that many bytes.
  function automatic void model_payload(input u8 p[$]);
    int n, pos, L;
    bit good;
    n = p.size();
    pos = 0;
    while (pos < n) begin
      if (n - pos == 1) begin
        exp_trunc++; exp_err++;
        break;
      end
      L = {p[pos], p[pos+1]};
      pos += 2;
      if (L == 0) continue;
      if (L > MAX_LEN) begin
        exp_over++; exp_err++;
        pos += L;
        continue;
      end
      if (n - pos < L) begin
        exp_trunc++; exp_err++;
        break;
      end
      for (int k = 0; k < L; k++) exp_bytes.push_back(p[pos+k]);
      exp_lens.push_back(L);
      good = 1;
`ifdef FRAMER_TYPE_CHECK_EN
      if (itch_len(p[pos]) != 0 && itch_len(p[pos]) != L) begin
        good = 0;
        exp_err++;
      end
`endif
      exp_valid.push_back(good);
      pos += L;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic send_byte(input u8 d, input bit last, input int gap);
    int w;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 0;
      in_data = 8'($urandom);
      in_last = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1;
    in_data = d;
    in_last = last;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      total++; bad++;
      $display("FAIL in_ready_timeout: got 0 required 1");
    end
    @(posedge clk);
    last_acc_cyc = cyc;
  endtask

  task automatic send_payload(input u8 p[$], input int mode);
    int g;
    for (int i = 0; i < p.size(); i++) begin
      if (mode == 0) g = 0;
      else if (mode == 1) g = 1;
      else g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_byte(p[i], i == p.size() - 1, g);
    end
    @(negedge clk);
    in_valid = 0;
    in_last = 0;
    repeat (70) @(negedge clk);
  endtask

  task automatic compare_msgs(input string tag);
    int gl, el, diff;
    bit gv, ev;
    u8 gb, eb;
    check({tag, "_msg_count"}, got_lens.size(), exp_lens.size());
    while (got_lens.size() > 0 && exp_lens.size() > 0) begin
      gl = got_lens.pop_front();
      el = exp_lens.pop_front();
      gv = got_valid.pop_front();
      ev = exp_valid.pop_front();
      check({tag, "_len"}, gl, el);
      check({tag, "_valid"}, gv, ev);
      diff = 0;
      for (int k = 0; k < gl || k < el; k++) begin
        gb = (k < gl && got_bytes.size() > 0) ? got_bytes.pop_front() : 8'h00;
        eb = (k < el && exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'h00;
        if (k < gl && k < el && gb != eb) diff++;
      end
      check({tag, "_bytes_wrong"}, diff, 0);
    end
    got_lens.delete(); got_bytes.delete(); got_valid.delete();
    exp_lens.delete(); exp_bytes.delete(); exp_valid.delete();
    check({tag, "_trunc_pulses"}, trunc_seen, exp_trunc);
    check({tag, "_oversize_pulses"}, over_seen, exp_over);
    check({tag, "_err_count"}, err_count, (exp_err > CNT_MAX) ? CNT_MAX : exp_err);
  endtask

  task automatic run_random();
    u8 p[$];
    u8 t;
    bit stop;
    int items, kind, L, nb, r;
    for (int pl = 0; pl < 40; pl++) begin
      p.delete();
      stop = 0;
      items = $urandom_range(1, 3);
      for (int it = 0; it < items && !stop; it++) begin
        kind = $urandom_range(0, 9);
        t = 8'($urandom);
        if (kind < 5) begin
          r = $urandom_range(0, 7);
          if (r < 6) t = types[r];
          L = (itch_len(t) != 0 && $urandom_range(0, 3) != 0) ? itch_len(t) : int'($urandom_range(1, MAX_LEN));
          nb = L;
        end else if (kind == 5) begin
          L = 0; nb = 0;
        end else if (kind < 8) begin
          L = $urandom_range(MAX_LEN + 1, 100);
          nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L - 1)) : L;
          stop = (nb < L);
        end else if (kind == 8) begin
          L = $urandom_range(1, MAX_LEN);
          nb = $urandom_range(0, L - 1);
          stop = 1;
        end else begin
          L = -1; nb = 0;
          stop = 1;
        end
        if (L < 0) begin
          p.push_back(8'($urandom));
        end else begin
          p.push_back(8'(L >> 8));
          p.push_back(8'(L));
          for (int k = 0; k < nb; k++) p.push_back((k == 0) ? t : 8'($urandom));
        end
      end
      if (p.size() == 0) p.push_back(8'h00);
      $display("random payload %0d: %0d bytes", pl, p.size());
      model_payload(p);
      send_payload(p, 2);
      compare_msgs("rnd");
    end
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[12];

  initial begin
    u8 p[$];
    int tr0, ov0;
    bit vexp;

    vecs[0]  = '{16'd36, 36, 8'h41, 1, 0, 0, 0};
    vecs[1]  = '{16'd36, 20, 8'h41, 0, 1, 0, 0};
    vecs[2]  = '{16'd80, 80, 8'h41, 0, 0, 1, 0};
    vecs[3]  = '{16'd1,  1,  8'h5A, 1, 0, 0, 0};
    vecs[4]  = '{16'd0,  0,  8'h00, 0, 0, 0, 0};
    vecs[5]  = '{16'd64, 64, 8'h21, 1, 0, 0, 0};
    vecs[6]  = '{16'd65, 65, 8'h21, 0, 0, 1, 0};
    vecs[7]  = '{16'd80, 10, 8'h21, 0, 0, 1, 0};
    vecs[8]  = '{16'd19, 19, 8'h44, 1, 0, 0, 0};
    vecs[9]  = '{16'd5,  0,  8'h21, 0, 1, 0, 0};
    vecs[10] = '{16'd32, 32, 8'h41, 1, 0, 0, 1};
    vecs[11] = '{16'd2,  2,  8'h58, 1, 0, 0, 1};

    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_valid", valid, 0);
    check("reset_start", start_msg, 0);
    check("reset_end", end_msg, 0);
    check("reset_message", message, 0);
    check("reset_err_trunc", err_trunc, 0);
    check("reset_err_oversize", err_oversize, 0);
    check("reset_err_count", err_count, 0);

    for (int i = 0; i < 12; i++) begin
      p.delete();
      p.push_back(vecs[i].len[15:8]);
      p.push_back(vecs[i].len[7:0]);
      for (int k = 0; k < vecs[i].nbody; k++) p.push_back((k == 0) ? vecs[i].typ : 8'($urandom));
      tr0 = trunc_seen;
      ov0 = over_seen;
      $display("vector %0d: len=%0d body=%0d", i, vecs[i].len, vecs[i].nbody);
      model_payload(p);
      send_payload(p, (i == 0) ? 1 : i % 3);
      check("vec_msgs", got_lens.size(), vecs[i].exp_msgs);
      check("vec_trunc", trunc_seen - tr0, vecs[i].exp_tr);
      check("vec_oversize", over_seen - ov0, vecs[i].exp_ov);
      if (vecs[i].exp_msgs == 1 && got_valid.size() == 1) begin
        vexp = 1;
`ifdef FRAMER_TYPE_CHECK_EN
        vexp = !vecs[i].tmis;
`endif
        check("vec_valid", got_valid[0], vexp);
        check("vec_latency", last_start_cyc - last_acc_cyc, 1);
      end
      compare_msgs("vec");
    end

    // D(19) and X(23) back to back in one payload
    p.delete();
    p.push_back(8'h00); p.push_back(8'd19);
    for (int k = 0; k < 19; k++) p.push_back((k == 0) ? 8'h44 : 8'(k));
    p.push_back(8'h00); p.push_back(8'd23);
    for (int k = 0; k < 23; k++) p.push_back((k == 0) ? 8'h58 : 8'(100 + k));
    $display("sequence back_to_back: %0d bytes", p.size());
    tr0 = trunc_seen;
    model_payload(p);
    send_payload(p, 0);
    check("b2b_msgs", got_lens.size(), 2);
    check("b2b_no_trunc", trunc_seen - tr0, 0);
    check("b2b_latency", last_start_cyc - last_acc_cyc, 1);
    compare_msgs("b2b");

    // payload ending on the high length byte
    p.delete();
    p.push_back(8'h00);
    $display("sequence lone_len_byte");
    tr0 = trunc_seen;
    model_payload(p);
    send_payload(p, 0);
    check("lone_trunc", trunc_seen - tr0, 1);
    compare_msgs("lone");

    // reset in the middle of a burst
    p.delete();
    p.push_back(8'h00); p.push_back(8'd36);
    for (int k = 0; k < 36; k++) p.push_back((k == 0) ? 8'h41 : 8'($urandom));
    $display("sequence reset_mid_play");
    for (int i = 0; i < p.size(); i++) send_byte(p[i], i == p.size() - 1, 0);
    @(negedge clk);
    in_valid = 0; in_last = 0;
    repeat (4) @(negedge clk);
    check("midplay_in_burst", in_burst, 1);
    check("midplay_in_ready", in_ready, 0);
    rst = 1;
    @(negedge clk);
    check("midplay_rst_valid", valid, 0);
    check("midplay_rst_start", start_msg, 0);
    check("midplay_rst_end", end_msg, 0);
    check("midplay_rst_message", message, 0);
    rst = 0;
    @(negedge clk);
    check("midplay_after_in_ready", in_ready, 1);
    check("midplay_after_err_count", err_count, 0);
    repeat (40) @(negedge clk);
    check("midplay_no_end_msg", got_lens.size(), 0);
    exp_err = 0;
    compare_msgs("post_rst");

    run_random();

    check("ready_low_during_burst", ready_viol, 0);
    check("idle_outputs_zero", idle_viol, 0);
    check("valid_uniform_per_msg", mixed_valid, 0);
    check("burst_runaway", runaway, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/itch_framer.md
# itch_framer

Upstream stage of `parser`: accepts a gappy byte stream of 2-byte big-endian length-prefixed ITCH 5.0 messages (MoldUDP64 payload order), buffers each complete message, and replays it to `parser` as a contiguous burst, one byte per cycle, with `start_msg`/`end_msg` framing. `parser` has no backpressure and requires gap-free messages, so this block owns all stalling and length/error policing. Stalls on its input side while replaying.

## Interface
- `MAX_LEN`, 64: largest accepted message body in bytes (length field value); buffer depth.
- `CNT_W`, 16: width of the error counter.
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: input byte.
- `in_valid` input 1: `in_data` present this cycle.
- `in_last` input 1: qualifies `in_valid`; last byte of the current UDP payload.
- `in_ready` output 1: byte accepted when `in_valid && in_ready`.
- `message` output 8: byte to `parser`.
- `valid` output 1: byte-good flag to `parser`; 1 on every good message byte.
- `start_msg` output 1: first byte of a message.
- `end_msg` output 1: last byte of a message.
- `err_trunc` output 1: one-cycle pulse, payload ended mid-message.
- `err_oversize` output 1: one-cycle pulse, length field > `MAX_LEN`.
- `err_count` output CNT_W: saturating count of all error events.

## Operation
- States: LEN_HI, LEN_LO, BODY, SKIP, PLAY. Reset state LEN_HI.
- LEN_HI: accepted byte -> `len[15:8]`; `in_last` -> `err_trunc`, stay LEN_HI; else LEN_LO.
- LEN_LO: accepted byte -> `len[7:0]`. len==0 -> LEN_HI (no output, no error, `in_last` legal). len>`MAX_LEN` -> pulse `err_oversize`, SKIP (or LEN_HI if `in_last`). Otherwise `in_last` -> `err_trunc`, LEN_HI; else BODY with `wr_idx`=0.
- BODY: each accepted byte written at `wr_idx`, `wr_idx`++. Byte number len accepted -> PLAY (`in_last` on it is legal). `in_last` earlier -> `err_trunc`, discard buffer, LEN_HI.
- SKIP: consume and discard len bytes, then LEN_HI; `in_last` earlier -> LEN_HI, no second error.
- PLAY: `in_ready`=0; emit buffer bytes 0..len-1 on consecutive cycles, `valid`=1, `start_msg` on byte 0, `end_msg` on byte len-1 (both on same cycle when len==1). After last byte -> LEN_HI.
- `in_ready`=1 in every state except PLAY.
- `err_count` increments by 1 per `err_trunc` or `err_oversize` pulse, saturates at all-ones.
- Outside PLAY: `message`=0, `valid`=0, `start_msg`=0, `end_msg`=0.

## Timing
- Reset values: all outputs 0 except `in_ready`=1 (from the cycle after reset deasserts); `len`, indices, counter cleared.
- Latency: first output byte on the cycle after the final body byte is accepted; burst lasts exactly len cycles; `in_ready` returns high the cycle after `end_msg`.
- Outputs registered; error pulses appear the cycle after the offending byte is accepted.
- `rst` mid-PLAY: outputs go to 0 next cycle, no `end_msg` issued; buffer contents abandoned.
- `in_valid` low cycles in any input state: no state change.

## Configuration
- `FRAMER_TYPE_CHECK_EN` defined: during PLAY, if buffer byte 0 is A/F/E/X/D/U and len ≠ its ITCH length (36/40/31/23/19/35), message is still framed but `valid`=0 on every byte so `parser` rejects it; counts in `err_count`. Unknown types unchecked.
- Undefined: no type/length check; `valid`=1 on all replayed bytes.

## Structure
- `itch_pkg`: message-type byte constants, per-type length constants, `expected_len(type)` function, state enum.
- One sub-module `itch_msg_buf`: `MAX_LEN`x8 simple dual-port buffer, one write port, one registered read port.

## Test plan
- Length 0x0024 then 36-byte 'A' message, `in_valid` toggling every other cycle -> 36-cycle contiguous burst, `start_msg` with 0x41, `end_msg` with final byte 0x03, all `valid`=1.
- Two back-to-back messages (D len 19, X len 23) in one payload with `in_last` on final byte -> two bursts, `in_ready` low during each, no errors.
- Length 0x0024 but `in_last` after 20 body bytes -> no output, `err_trunc` pulse, `err_count`=1; next message frames normally.
- Length 0x0050 (80 > 64) -> `err_oversize`, 80 bytes consumed, no output, following message correct.
- Length 0x0001, byte 0x5A -> single cycle with `start_msg`=`end_msg`=1, `message`=0x5A.
- With `FRAMER_TYPE_CHECK_EN`: length 0x0020 with type 'A' -> 32-byte burst, `valid`=0 throughout, `err_count` +1; without macro -> `valid`=1.
